// File: rtl/soc_top.sv
// Tiny SoC: 256-word SRAM plus a GPIO block on a simple strobe bus.
// Define SOC_GPIO_SYNC_EN to put gpio_in through a two-flop synchronizer.
module soc_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wr_en,
  input  logic        bus_rd_en,
  output logic [31:0] bus_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out
);

  localparam logic [5:0] OFF_DATA = 6'h00;
  localparam logic [5:0] OFF_DIR  = 6'h01;
  localparam logic [5:0] OFF_IN   = 6'h02;
  localparam logic [5:0] OFF_SET  = 6'h03;
  localparam logic [5:0] OFF_CLR  = 6'h04;
  localparam logic [5:0] OFF_TGL  = 6'h05;

  logic [31:0] data_q, data_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_val;
  logic [31:0] in_val;
  logic [31:0] mem_q [256];

  logic       sram_hit;
  logic       gpio_hit;
  logic [7:0] widx;
  logic [5:0] off;
  logic       unused_addr;

  assign sram_hit    = (bus_addr[31:10] == 22'd0);
  assign gpio_hit    = (bus_addr[31:8] == 24'h40_0000);
  assign widx        = bus_addr[9:2];
  assign off         = bus_addr[7:2];
  assign unused_addr = ^bus_addr[1:0];

`ifdef SOC_GPIO_SYNC_EN
  logic [31:0] sync1_q;
  logic [31:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_val = sync2_q;
`else
  assign in_val = gpio_in;
`endif

  // Read mux sees pre-write state, so read+write returns the old value.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sram_hit: rd_val = mem_q[widx];
      gpio_hit: begin
        case (off)
          OFF_DATA: rd_val = data_q;
          OFF_DIR:  rd_val = dir_q;
          OFF_IN:   rd_val = in_val;
          default:  rd_val = '0;
        endcase
      end
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    rdata_d = rdata_q;
    if (bus_rd_en) begin
      rdata_d = rd_val;
    end
    if (bus_wr_en && gpio_hit) begin
      case (off)
        OFF_DATA: data_d = bus_wdata;
        OFF_DIR:  dir_d  = bus_wdata;
        OFF_SET:  data_d = data_q | bus_wdata;
        OFF_CLR:  data_d = data_q & ~bus_wdata;
        OFF_TGL:  data_d = data_q ^ bus_wdata;
        default:  data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      dir_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM contents survive reset; only the write is blocked.
  always_ff @(posedge clk) begin
    if (bus_wr_en && sram_hit && !rst) begin
      mem_q[widx] <= bus_wdata;
    end
  end

  assign bus_rdata = rdata_q;
  assign gpio_out  = data_q & dir_q;

endmodule

// File: tb/tb_soc_top.sv
// Random and directed bench for soc_top.
// Reference model tracks the memory map at register level.
module tb_soc_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;

  soc_top dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr_en (bus_wr_en),
    .bus_rd_en (bus_rd_en),
    .bus_rdata (bus_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_data, m_dir, m_rd;
  logic [31:0] m_s1, m_s2;
  logic [31:0] m_sram [256];
  int          written [$];
  bit          rand_in = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a,
                                         input logic [31:0] inv);
    if (a < 32'h400) return m_sram[a[9:2]];
    if (a >= 32'h4000_0000 && a <= 32'h4000_00FF) begin
      case (a[7:0] & 8'hFC)
        8'h00:   return m_data;
        8'h04:   return m_dir;
        8'h08:   return inv;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'h400) begin
      m_sram[a[9:2]] = d;
      written.push_back(int'(a[9:2]));
    end else if (a >= 32'h4000_0000 && a <= 32'h4000_00FF) begin
      case (a[7:0] & 8'hFC)
        8'h00: m_data = d;
        8'h04: m_dir  = d;
        8'h0C: m_data = m_data | d;
        8'h10: m_data = m_data & ~d;
        8'h14: m_data = m_data ^ d;
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    m_data = '0;
    m_dir  = '0;
    m_rd   = '0;
    m_s1   = '0;
    m_s2   = '0;
  endtask

  task automatic bus(input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] inv;
    if (rand_in) gpio_in = $urandom;
    bus_wr_en = wr;
    bus_rd_en = rd;
    bus_addr  = a;
    bus_wdata = d;
`ifdef SOC_GPIO_SYNC_EN
    inv = m_s2;
`else
    inv = gpio_in;
`endif
    if (rd) m_rd = m_read(a, inv);
    if (wr) m_write(a, d);
    @(posedge clk);
    m_s2 = m_s1;
    m_s1 = gpio_in;
    #1;
    chk("rdata", bus_rdata, m_rd);
    chk("gpio_out", gpio_out, m_data & m_dir);
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    rst       = 1'b1;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    gpio_in   = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    rst = 1'b0;

    bus(1, 0, 32'h4000_0004, 32'hFF);
    bus(1, 0, 32'h4000_0000, 32'hAA);
    chk("dir_data_out", gpio_out, 32'hAA);
    bus(0, 1, 32'h4000_0000, 0);
    chk("rd_data", bus_rdata, 32'hAA);
    bus(0, 1, 32'h4000_0004, 0);
    chk("rd_dir", bus_rdata, 32'hFF);

    gpio_in = 32'h1234_5678;
    bus(0, 0, 0, 0);
    bus(0, 0, 0, 0);
    bus(0, 1, 32'h4000_0008, 0);
    chk("rd_in", bus_rdata, 32'h1234_5678);

    bus(1, 0, 32'h4000_000C, 32'h0F);
    chk("set", gpio_out, 32'hAF);
    bus(1, 0, 32'h4000_0010, 32'h03);
    chk("clr", gpio_out, 32'hAC);
    bus(1, 0, 32'h4000_0014, 32'hFF);
    chk("tgl", gpio_out, 32'h53);
    bus(0, 1, 32'h4000_000C, 0);
    chk("rd_wo", bus_rdata, 32'h0);

    bus(1, 0, 32'h0000_0010, 32'hCAFE_F00D);
    bus(0, 1, 32'h0000_0010, 0);
    chk("sram_rd", bus_rdata, 32'hCAFE_F00D);
    bus(0, 1, 32'h2000_0000, 0);
    chk("unmapped_rd", bus_rdata, 32'h0);

    bus(0, 1, 32'h4000_0000, 0);
    bus(1, 1, 32'h4000_0000, 32'h5555_0001);
    chk("rw_old", bus_rdata, 32'h53);
    bus(0, 0, 0, 0);

    rand_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0: bus(1, $urandom_range(0, 1) == 1,
               {22'd0, 8'($urandom), 2'($urandom)}, $urandom);
        1: begin
          if (written.size() > 0) begin
            a = {22'd0, 8'(written[$urandom_range(0, written.size() - 1)]),
                 2'($urandom)};
            bus(0, 1, a, 0);
          end else begin
            bus(0, 0, 0, 0);
          end
        end
        2, 3: bus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {24'h40_0000, 2'b00, 4'($urandom_range(0, 7)), 2'($urandom)},
                  $urandom);
        default: begin
          a = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h8000_0000)
                                          : (32'h4000_0100 + 32'($urandom_range(0, 4095)));
          bus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom);
        end
      endcase
    end
    rand_in = 1'b0;

    bus(1, 0, 32'h4000_0004, 32'hFF);
    bus(1, 0, 32'h4000_0000, 32'hAA);
    bus(0, 1, 32'h4000_0000, 0);
    chk("pre_rst_out", gpio_out, 32'hAA);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", gpio_out, 32'h0);
    chk("async_rst_rdata", bus_rdata, 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus(0, 1, 32'h4000_0004, 0);
    chk("post_rst_dir", bus_rdata, 32'h0);
    bus(0, 1, 32'h0000_0010, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_top.md
SOC_TOP -- requirements
Module: soc_top

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-high.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port bus_addr, input, 32 bits: byte address of the bus access.
REQ-005 Port bus_wdata, input, 32 bits: write data.
REQ-006 Port bus_wr_en, input, 1 bit: write strobe, sampled on the rising edge.
REQ-007 Port bus_rd_en, input, 1 bit: read strobe, sampled on the rising edge.
REQ-008 Port bus_rdata, output, 32 bits: registered read data.
REQ-009 Port gpio_in, input, 32 bits: external GPIO pin levels.
REQ-010 Port gpio_out, output, 32 bits: driven GPIO pin levels.

Function
REQ-011 The address map SHALL be: SRAM 0x0000_0000-0x0000_03FF (256 x 32-bit words); GPIO block at 0x4000_0000-0x4000_00FF.
REQ-012 GPIO registers SHALL be at these offsets:
- 0x00 DATA, R/W
- 0x04 DIR, R/W, 1 = output
- 0x08 IN, read-only, returns gpio_in
- 0x0C SET, write-only: DATA |= wdata
- 0x10 CLR, write-only: DATA &= ~wdata
- 0x14 TGL, write-only: DATA ^= wdata
REQ-013 Writes SHALL take effect on the rising edge where bus_wr_en=1; address bits [1:0] are ignored (word access only).
REQ-014 Reads SHALL have one-cycle latency: bus_rdata is updated on the edge where bus_rd_en=1 and holds its value otherwise.
REQ-015 Reads of write-only registers, unmapped GPIO offsets, and unmapped addresses SHALL return 0x0000_0000; writes to them SHALL have no effect.
REQ-016 Simultaneous bus_wr_en and bus_rd_en SHALL perform both operations; the read returns the pre-write value.
REQ-017 gpio_out[i] SHALL equal DATA[i] when DIR[i]=1, else 0; the output is combinational from the registers.
REQ-018 SRAM SHALL be addressed by bus_addr[9:2]; its contents are not reset.

Reset
REQ-019 While rst=1, DATA, DIR and bus_rdata SHALL be 0x0000_0000 and gpio_out SHALL be 0; any access in progress is discarded.
REQ-020 The first access SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-021 With SOC_GPIO_SYNC_EN defined, gpio_in SHALL pass through a two-flop synchronizer (reset to 0) before IN reads, adding two cycles of input latency.
REQ-022 Without SOC_GPIO_SYNC_EN, IN reads SHALL sample gpio_in directly.

Verification
REQ-023 Reset, write DIR=0x0000_00FF, then DATA=0x0000_00AA -> gpio_out=0x0000_00AA one cycle after the DATA write.
REQ-024 Read 0x4000_0000, then 0x4000_0004 -> bus_rdata=0x0000_00AA, then 0x0000_00FF, each one cycle after rd_en.
REQ-025 gpio_in=0x1234_5678 held, read 0x4000_0008 -> bus_rdata=0x1234_5678.
REQ-026 DATA=0xAA, DIR=0xFF:
- write SET=0x0F -> DATA 0xAF
- write CLR=0x03 -> DATA 0xAC
- write TGL=0xFF -> DATA 0x53
- gpio_out tracks DATA.
REQ-027 Write SRAM 0x0000_0010=0xCAFE_F00D; read 0x0000_0010 -> 0xCAFE_F00D; read 0x2000_0000 -> 0x0000_0000.
REQ-028 Assert rst mid-operation with DATA=0xAA -> gpio_out and bus_rdata are 0 immediately, without waiting for a clock edge.
